// File: rtl/apb_timer_array.sv
// apb_timer_array: APB bank of NUM_CH down-counters with periodic, free-run and one-shot modes,
// maskable interrupts and ETB enable/trigger hooks.
module apb_timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [7:0]        paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    input  logic [NUM_CH-1:0] etb_trig_en_on,
    input  logic [NUM_CH-1:0] etb_trig_en_off,
    output logic [NUM_CH-1:0] etb_trig,
    output logic [NUM_CH-1:0] intr
);
    logic [5:0]        word;
    logic              wr_acc;
    logic              rd_acc;
    logic              eoi_all;
    logic [NUM_CH-1:0] raw_v;
    logic [31:0]       rd_ch [NUM_CH];

    assign word    = paddr[7:2];
    assign wr_acc  = psel & penable & pwrite;
    assign rd_acc  = psel & penable & ~pwrite;
    assign eoi_all = rd_acc && word == 6'h29;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [5:0] BASE = 6'(5 * c);
        logic [CNT_W-1:0] load_q, load_d, cur_q, cur_d;
        logic [3:0]       ctrl_q, ctrl_d;
        logic             raw_q, raw_d, start_q, start_d, trig_q, trig_d;
        logic             hit, expire, wr_ctrl, en_nx;
        logic [5:0]       off;
        always_comb begin
            off     = word - BASE;
            hit     = word >= BASE && word < BASE + 6'd5;
            wr_ctrl = wr_acc && hit && off == 6'd2;
            // the cycle right after an EN rising edge is a load cycle, never an expiry
            expire  = ctrl_q[0] && !start_q && cur_q == '0;
            load_d  = wr_acc && hit && off == 6'd0 ? pwdata[CNT_W-1:0] : load_q;
            en_nx   = wr_ctrl ? pwdata[0] : ctrl_q[0] && !(expire && ctrl_q[3]);
            ctrl_d  = {wr_ctrl ? pwdata[3:1] : ctrl_q[3:1],
                       etb_trig_en_off[c] ? 1'b0 : etb_trig_en_on[c] | en_nx};
            start_d = ctrl_d[0] && !ctrl_q[0];
            cur_d   = start_q && ctrl_q[0] ? load_q :
                      expire ? (ctrl_q[3] ? '0 : ctrl_q[1] ? '1 : load_q) :
                      ctrl_q[0] ? cur_q - CNT_W'(1) : cur_q;
            raw_d   = expire || raw_q && !(eoi_all || rd_acc && hit && off == 6'd3);
            trig_d  = expire;
        end
        always_ff @(posedge pclk) begin
            if (preset) begin
                load_q  <= '0;
                cur_q   <= '0;
                ctrl_q  <= '0;
                raw_q   <= 1'b0;
                start_q <= 1'b0;
                trig_q  <= 1'b0;
            end else begin
                load_q  <= load_d;
                cur_q   <= cur_d;
                ctrl_q  <= ctrl_d;
                raw_q   <= raw_d;
                start_q <= start_d;
                trig_q  <= trig_d;
            end
        end
        assign intr[c]     = raw_q & ~ctrl_q[2];
        assign etb_trig[c] = trig_q;
        assign raw_v[c]    = raw_q;
        assign rd_ch[c]    = !hit ? '0 :
                             off == 6'd0 ? 32'(load_q) :
                             off == 6'd1 ? 32'(cur_q) :
                             off == 6'd2 ? {28'd0, ctrl_q} :
                             off == 6'd4 ? {31'd0, intr[c]} : '0;
    end

    always_comb begin
        prdata = '0;
        for (int i = 0; i < NUM_CH; i++) prdata = prdata | rd_ch[i];
        prdata = word == 6'h28 || word == 6'h29 ? 32'(intr) : word == 6'h2A ? 32'(raw_v) : prdata;
        prdata = psel && !pwrite ? prdata : '0;
    end
endmodule

// File: tb/tb_apb_timer_array.sv
// tb_apb_timer_array: directed bench for a 4x32 and an 8x16 timer bank sharing one APB bus.
module tb_apb_timer_array;
    logic        clk = 1'b0;
    logic        preset, psel, penable, pwrite, dsel;
    logic [7:0]  paddr;
    logic [31:0] pwdata, prdata_a, prdata_b, prdata;
    logic [3:0]  on_a, off_a, trig_a, intr_a;
    logic [7:0]  on_b, off_b, trig_b, intr_b;
    logic [31:0] sb [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cnt;

    always #5 clk = ~clk;
    assign prdata = dsel ? prdata_b : prdata_a;

    apb_timer_array #(.NUM_CH(4), .CNT_W(32)) dut_a (
        .pclk(clk), .preset(preset), .psel(psel & ~dsel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_a), .etb_trig_en_on(on_a),
        .etb_trig_en_off(off_a), .etb_trig(trig_a), .intr(intr_a)
    );

    apb_timer_array #(.NUM_CH(8), .CNT_W(16)) dut_b (
        .pclk(clk), .preset(preset), .psel(psel & dsel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_b), .etb_trig_en_on(on_b),
        .etb_trig_en_off(off_b), .etb_trig(trig_b), .intr(intr_b)
    );

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] want;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s no expected value queued, observed=%h", tag, obs);
        end else begin
            want = sb.pop_front();
            assert (obs === want) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, want);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        sb.push_back(want);
        cmp(tag, obs);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    // setup-phase look at prdata without an access phase, so no read side effects
    task automatic peek(input logic [7:0] a, input logic [31:0] want, input string tag);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        sb.push_back(want);
        #1;
        cmp(tag, prdata);
        psel = 1'b0;
        tick(1);
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] want, input string tag);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        sb.push_back(want);
        #1;
        cmp(tag, prdata);
        tick(1);
        penable = 1'b1;
        tick(1);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        dsel = 1'b0; on_a = '0; off_a = '0; on_b = '0; off_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_intr", 32'(intr_a), 0);
        chk("rst_trig", 32'(trig_a), 0);
        preset = 1'b0;
        peek(8'h00, 0, "rst_load");
        peek(8'h04, 0, "rst_cur");
        peek(8'h08, 0, "rst_ctrl");
        peek(8'hA8, 0, "rst_raw");
        // periodic ch0, LOAD=3
        wr(8'h00, 3);
        wr(8'h08, 1);
        tick(1);
        for (int k = 0; k < 9; k++) begin
            chk("per_trig", 32'(trig_a[0]), 32'(k > 0 && k % 4 == 0));
            chk("per_intr", 32'(intr_a[0]), 32'(k >= 4));
            peek(8'h04, 32'(3 - k % 4), "per_cur");
        end
        rd(8'h10, 1, "per_intstat");
        rd(8'h0C, 0, "per_eoi");
        chk("per_eoi_clr", 32'(intr_a[0]), 0);
        wr(8'h08, 0);
        // one-shot ch1
        wr(8'h14, 2);
        wr(8'h1C, 9);
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            cnt += int'(trig_a[1]);
            tick(1);
        end
        chk("os_trigs", 32'(cnt), 1);
        rd(8'h1C, 8, "os_ctrl");
        peek(8'h18, 0, "os_cur");
        // free-run ch2
        wr(8'h28, 1);
        wr(8'h30, 3);
        tick(3);
        peek(8'h2C, 32'hFFFF_FFFF, "fr_cur");
        wr(8'h30, 0);
        peek(8'h2C, 32'hFFFF_FFFC, "fr_freeze");
        rd(8'hA4, 32'h6, "eoi_all");
        peek(8'hA8, 0, "raw_clr");
        // masked ch0
        wr(8'h00, 1);
        wr(8'h08, 5);
        tick(4);
        peek(8'hA8, 1, "mask_raw");
        chk("mask_intr", 32'(intr_a[0]), 0);
        peek(8'hA0, 0, "mask_intstat");
        wr(8'h08, 0);
        rd(8'h0C, 0, "mask_eoi");
        // EOI read side effect lands on the expiry edge
        wr(8'h00, 2);
        wr(8'h08, 1);
        tick(2);
        rd(8'h0C, 0, "col_eoi");
        chk("col_intr", 32'(intr_a[0]), 1);
        peek(8'hA8, 1, "col_raw");
        wr(8'h08, 0);
        // ETB enable control on ch3
        wr(8'h3C, 5);
        on_a = 4'b1000;
        tick(1);
        on_a = '0;
        peek(8'h44, 1, "etb_en");
        peek(8'h40, 5, "etb_cur");
        peek(8'h40, 4, "etb_dec");
        off_a = 4'b1000;
        tick(1);
        off_a = '0;
        peek(8'h44, 0, "etb_off");
        peek(8'h40, 2, "etb_frz");
        on_a = 4'b1000; off_a = 4'b1000;
        tick(1);
        on_a = '0; off_a = '0;
        peek(8'h44, 0, "etb_both");
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 8'h44; pwdata = 32'h4;
        tick(1);
        penable = 1'b1; on_a = 4'b1000;
        tick(1);
        psel = 1'b0; penable = 1'b0; on_a = '0;
        peek(8'h44, 5, "etb_apb");
        wr(8'h44, 0);
        wr(8'h50, 32'hABCD);
        peek(8'h50, 0, "unused_ch");
        peek(8'hB0, 0, "unmapped");
        // 8-channel, 16-bit bank
        dsel = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'(i * 20), 32'(i));
        for (int i = 0; i < 8; i++) wr(8'(i * 20 + 8), 1);
        tick(20);
        peek(8'hA0, 32'hFF, "b_intstat");
        chk("b_intr", 32'(intr_b), 32'hFF);
        for (int i = 0; i < 8; i++) wr(8'(i * 20 + 8), 0);
        rd(8'hA4, 32'hFF, "b_eoi_all");
        peek(8'hA8, 0, "b_raw_clr");
        wr(8'h00, 32'h12345);
        peek(8'h00, 32'h2345, "b_trunc");
        // reset while counting
        dsel = 1'b0;
        wr(8'h00, 0);
        wr(8'h08, 1);
        tick(3);
        chk("mid_trig_pre", 32'(trig_a[0]), 1);
        preset = 1'b1;
        tick(1);
        chk("mid_trig", 32'(trig_a), 0);
        chk("mid_intr", 32'(intr_a), 0);
        preset = 1'b0;
        peek(8'h08, 0, "mid_ctrl");
        peek(8'h00, 0, "mid_load");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
